nway_cache_control: RTL

NWAY_CACHE_CONTROL -- requirements
Module: nway_cache_control

---
 rtl/nway_cache_control.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/nway_cache_control.sv
// N-way set-associative cache controller: hit/miss handling, victim
// write-back, line refill, full-cache flush walk and saturating counters.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   cmp, dirty, valid [WAYS]         per-way tag match / dirty / valid
//   lru [WB]                         victim way from replacement array
//   mem_read, mem_write, flush       CPU request and flush pulse
//   cacheline_resp                   memory done
//   sel, mru [WB]                    data-array way, way reported to LRU
//   data_in_sel                      0 = CPU data, 1 = memory line
//   write_en, load_tag [WAYS]        per-way data write, tag load
//   load_lru/dirty/valid             metadata loads
//   dirty_in, valid_in [WAYS]        metadata next values
//   resp                             CPU done
//   cacheline_read/write             memory request
//   flush_busy, flush_set, flush_done flush walk status / set override
//   hit_count, miss_count, wb_count  saturating performance counters
module nway_cache_control #(
  parameter  int WAYS     = 8,
  parameter  int SET_BITS = 3,
  parameter  int CNT_W    = 32,
  localparam int WB       = $clog2(WAYS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WAYS-1:0]     cmp,
  input  logic [WAYS-1:0]     dirty,
  input  logic [WAYS-1:0]     valid,
  input  logic [WB-1:0]       lru,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic                flush,
  input  logic                cacheline_resp,
  output logic [WB-1:0]       sel,
  output logic                data_in_sel,
  output logic [WAYS-1:0]     write_en,
  output logic [WAYS-1:0]     load_tag,
  output logic                load_lru,
  output logic                load_dirty,
  output logic                load_valid,
  output logic [WB-1:0]       mru,
  output logic [WAYS-1:0]     dirty_in,
  output logic [WAYS-1:0]     valid_in,
  output logic                resp,
  output logic                cacheline_read,
  output logic                cacheline_write,
  output logic                flush_busy,
  output logic [SET_BITS-1:0] flush_set,
  output logic                flush_done,
  output logic [CNT_W-1:0]    hit_count,
  output logic [CNT_W-1:0]    miss_count,
  output logic [CNT_W-1:0]    wb_count
);

  typedef enum logic [3:0] {
    IDLE, WRITE_BACK, META_UPDATE, READ_MEM, READ_END,
    WRITE_END, WAIT0, FLUSH_SCAN, FLUSH_WB, FLUSH_CLR,
    FLUSH_DONE
  } state_t;

  state_t              state;
  logic [WB-1:0]       victim;
  logic [SET_BITS-1:0] fset;
  logic [WB-1:0]       fway;
  logic                fpend;

  logic [WAYS-1:0]     hv;
  logic                hit;
  logic [WB-1:0]       hit_way;
  logic                req;
  logic                vdirty;
  logic                fl_act;
  logic [WB-1:0]       adv_way;
  logic [SET_BITS-1:0] adv_set;
  logic                adv_last;

  function automatic logic [CNT_W-1:0] sat(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

  assign hv     = cmp & valid;
  assign hit    = |hv;
  // exactly one of read/write; both together is ignored
  assign req    = mem_read ^ mem_write;
  assign vdirty = dirty[lru] & valid[lru];
  assign fl_act = state inside
    {FLUSH_SCAN, FLUSH_WB, FLUSH_CLR, FLUSH_DONE};
  assign flush_set = fset;

  // OR-encode: exact for one-hot, don't-care otherwise
  always_comb begin
    hit_way = '0;
    for (int i = 0; i < WAYS; i++)
      if (hv[i]) hit_way = hit_way | WB'(i);
  end

  // next position of the flush walk
  always_comb begin
    adv_way  = fway + 1'b1;
    adv_set  = fset;
    adv_last = 1'b0;
    if (&fway) begin
      adv_set  = fset + 1'b1;
      adv_last = &fset;
    end
  end

  always_comb begin
    sel             = hit_way;
    mru             = hit_way;
    valid_in        = valid;
    dirty_in        = dirty;
    data_in_sel     = 1'b0;
    write_en        = '0;
    load_tag        = '0;
    load_lru        = 1'b0;
    load_dirty      = 1'b0;
    load_valid      = 1'b0;
    resp            = 1'b0;
    cacheline_read  = 1'b0;
    cacheline_write = 1'b0;
    flush_busy      = 1'b0;
    flush_done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (req && hit) begin
          resp     = 1'b1;
          load_lru = 1'b1;
          if (mem_write) begin
            write_en          = hv;
            dirty_in[hit_way] = 1'b1;
            load_dirty        = 1'b1;
          end
        end else if (req && !vdirty) begin
          mru           = lru;
          load_lru      = 1'b1;
          load_tag[lru] = 1'b1;
          valid_in[lru] = 1'b1;
          dirty_in[lru] = mem_write;
          load_valid    = 1'b1;
          load_dirty    = 1'b1;
        end
      end
      WRITE_BACK: begin
        sel             = victim;
        cacheline_write = 1'b1;
      end
      META_UPDATE: begin
        mru              = victim;
        load_lru         = 1'b1;
        load_tag[victim] = 1'b1;
        valid_in[victim] = 1'b1;
        dirty_in[victim] = mem_write;
        load_valid       = 1'b1;
        load_dirty       = 1'b1;
      end
      READ_MEM: begin
        cacheline_read   = 1'b1;
        data_in_sel      = 1'b1;
        write_en[victim] = 1'b1;
      end
      READ_END: resp = 1'b1;
      WRITE_END: begin
        resp     = 1'b1;
        write_en = hv;
      end
      WAIT0: ;
      FLUSH_SCAN: begin
        flush_busy = 1'b1;
        sel        = fway;
      end
      FLUSH_WB: begin
        flush_busy      = 1'b1;
        sel             = fway;
        cacheline_write = 1'b1;
      end
      FLUSH_CLR: begin
        flush_busy     = 1'b1;
        sel            = fway;
        dirty_in[fway] = 1'b0;
        load_dirty     = 1'b1;
      end
      FLUSH_DONE: flush_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      victim     <= '0;
      fset       <= '0;
      fway       <= '0;
      fpend      <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      if (flush && !fl_act) fpend <= 1'b1;
      unique case (state)
        IDLE: begin
          if (req) begin
            if (hit) begin
              hit_count <= sat(hit_count);
            end else begin
              miss_count <= sat(miss_count);
              victim     <= lru;
              state      <= vdirty ? WRITE_BACK : READ_MEM;
            end
          end else if (!(mem_read && mem_write)
                       && (flush || fpend)) begin
            state <= FLUSH_SCAN;
            fset  <= '0;
            fway  <= '0;
            fpend <= 1'b0;
          end
        end
        WRITE_BACK: if (cacheline_resp) begin
          wb_count <= sat(wb_count);
          state    <= META_UPDATE;
        end
        META_UPDATE: state <= READ_MEM;
        READ_MEM: if (cacheline_resp)
          state <= mem_write ? WRITE_END : READ_END;
        READ_END:  state <= WAIT0;
        WRITE_END: state <= WAIT0;
        WAIT0:     state <= IDLE;
        FLUSH_SCAN: begin
          if (dirty[fway] && valid[fway]) begin
            state <= FLUSH_WB;
          end else begin
            fway  <= adv_way;
            fset  <= adv_set;
            state <= adv_last ? FLUSH_DONE : FLUSH_SCAN;
          end
        end
        FLUSH_WB: if (cacheline_resp) begin
          wb_count <= sat(wb_count);
          state    <= FLUSH_CLR;
        end
        FLUSH_CLR: begin
          fway  <= adv_way;
          fset  <= adv_set;
          state <= adv_last ? FLUSH_DONE : FLUSH_SCAN;
        end
        FLUSH_DONE: state <= IDLE;
        default:    state <= IDLE;
      endcase
    end
  end

endmodule
